multicycle_controller: RTL

Multi-cycle MIPS control unit: FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared-ALU datapath.
Supports addu, subu, slt, jr (R-type); ori, lui, lw, sw, beq, addi, addiu, j, jal.
Adds req/ready memory handshakes, a registered overflow flag and a selectable overflow mode.
Sits between the instruction register (opcode/funct) and the datapath muxes, PC, register file and memories.

---
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared-ALU datapath, with req/ready memory handshakes and addi overflow handling.
module multicycle_controller #(
  parameter int ALU_CTL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit OVF_MODE      = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 overflow,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           npc_sel,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 alu_src,
  output logic                 ext_op,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           reg_src,
  output logic                 illegal_op,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADDU, OP_SUBU, OP_SLT, OP_JR, OP_ORI, OP_LUI, OP_LW, OP_SW,
    OP_BEQ, OP_ADDI, OP_ADDIU, OP_J, OP_JAL, OP_ILLEGAL
  } op_t;

  localparam logic [ALU_CTL_W-1:0] ALU_ADD = ALU_CTL_W'(0);
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = ALU_CTL_W'(1);
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = ALU_CTL_W'(2);
  localparam logic [ALU_CTL_W-1:0] ALU_LUI = ALU_CTL_W'(3);
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = ALU_CTL_W'(4);

  state_t state_q, next_state;
  logic   ovf_q;
  op_t    op;
  logic   is_rtype;
  logic   imem_ok, dmem_ok;

  logic [ALU_CTL_W-1:0] op_alu_ctl;
  logic                 op_alu_src;
  logic                 op_ext_op;

  assign imem_ok  = !MEM_HANDSHAKE || imem_ready;
  assign dmem_ok  = !MEM_HANDSHAKE || dmem_ready;
  assign is_rtype = (op == OP_ADDU) || (op == OP_SUBU) || (op == OP_SLT);
  assign state    = state_q;

  always_comb begin
    op = OP_ILLEGAL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: op = OP_ADDU;
          6'b100011: op = OP_SUBU;
          6'b101010: op = OP_SLT;
          6'b001000: op = OP_JR;
          default:   op = OP_ILLEGAL;
        endcase
      end
      6'b001101: op = OP_ORI;
      6'b001111: op = OP_LUI;
      6'b100011: op = OP_LW;
      6'b101011: op = OP_SW;
      6'b000100: op = OP_BEQ;
      6'b001000: op = OP_ADDI;
      6'b001001: op = OP_ADDIU;
      6'b000010: op = OP_J;
      6'b000011: op = OP_JAL;
      default:   op = OP_ILLEGAL;
    endcase
  end

  // ALU setup for the current instruction; held through EXEC, MEM and WB.
  always_comb begin
    op_alu_ctl = ALU_ADD;
    op_alu_src = 1'b0;
    op_ext_op  = 1'b0;
    case (op)
      OP_SUBU:  op_alu_ctl = ALU_SUB;
      OP_SLT:   op_alu_ctl = ALU_SLT;
      OP_BEQ:   begin op_alu_ctl = ALU_SUB; op_ext_op = 1'b1; end
      OP_ORI:   begin op_alu_ctl = ALU_OR;  op_alu_src = 1'b1; end
      OP_LUI:   begin op_alu_ctl = ALU_LUI; op_alu_src = 1'b1; end
      OP_LW, OP_SW, OP_ADDI, OP_ADDIU: begin
        op_alu_src = 1'b1;
        op_ext_op  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state and flag registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == S_EXEC)
        ovf_q <= (op == OP_ADDI) && overflow;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_state = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    npc_sel    = 2'b00;
    alu_ctl    = ALU_ADD;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    reg_src    = 2'b00;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ok) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_J: begin
            pc_write   = 1'b1;
            npc_sel    = 2'b10;
            next_state = S_FETCH;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            npc_sel    = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            reg_src    = 2'b10;
            next_state = S_FETCH;
          end
          OP_JR: begin
            pc_write   = 1'b1;
            npc_sel    = 2'b11;
            next_state = S_FETCH;
          end
          OP_ILLEGAL: begin
            illegal_op = 1'b1;
            next_state = S_FETCH;
          end
          default: next_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_ctl = op_alu_ctl;
        alu_src = op_alu_src;
        ext_op  = op_ext_op;
        if (op == OP_BEQ) begin
          pc_write   = zero;
          npc_sel    = 2'b01;
          next_state = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        alu_ctl   = op_alu_ctl;
        alu_src   = op_alu_src;
        ext_op    = op_ext_op;
        dmem_req  = 1'b1;
        mem_write = (op == OP_SW);
        if (dmem_ok)
          next_state = (op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        alu_ctl    = op_alu_ctl;
        alu_src    = op_alu_src;
        ext_op     = op_ext_op;
        reg_write  = 1'b1;
        reg_dst    = is_rtype ? 2'b01 : 2'b00;
        reg_src    = (op == OP_LW) ? 2'b01 : 2'b00;
        next_state = S_FETCH;
        // Only addi traps; addiu results are always written back.
        if (op == OP_ADDI && ovf_q) begin
          if (OVF_MODE) begin
            reg_dst = 2'b11;
            reg_src = 2'b11;
          end else begin
            reg_write = 1'b0;
          end
        end
      end
      default: next_state = S_FETCH;
    endcase

    // Outputs are silent for the whole time reset is held.
    if (reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      npc_sel    = 2'b00;
      alu_ctl    = ALU_ADD;
      alu_src    = 1'b0;
      ext_op     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      reg_src    = 2'b00;
      illegal_op = 1'b0;
    end
  end

endmodule
